// File: rtl/seven_seg_pkg.sv
// Shared glyphs, nibble-to-segment decode and controller state encoding for the
// multiplexed seven-segment driver. Glyphs are active-low, segments a..g in bits 0..6.
package seven_seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_FORMAT = 2'd2
  } state_e;

  // Hex nibble to glyph; A-F use the usual A b C d E F shapes.
  function automatic logic [6:0] nib2seg(input logic [3:0] nib);
    logic [6:0] seg;
    seg = SEG_BLANK;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift step per cycle, WIDTH steps.
// done_c is high during the final step; bcd_o holds the result from the next cycle on.
module bin2bcd_seq #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned NDIG  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [WIDTH-1:0]      bin_i,
  output logic [4*NDIG-1:0]     bcd_o,
  output logic                  done_c
);
  import seven_seg_pkg::*;

  localparam int unsigned BCD_W = 4 * NDIG;
  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic                   run_q, run_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]       bin_q, bin_d;
  logic [BCD_W-1:0]       bcd_q, bcd_d;
  logic [BCD_W-1:0]       bcd_adj;
  logic [BCD_W+WIDTH-1:0] shifted;
  logic [3:0]             dig;

  assign done_c = run_q && (cnt_q == CNT_W'(WIDTH - 1));
  assign bcd_o  = bcd_q;

  always_comb begin
    bcd_adj = '0;
    dig     = '0;
    for (int i = 0; i < int'(NDIG); i++) begin
      dig = bcd_q[4*i +: 4];
      bcd_adj[4*i +: 4] = (dig >= 4'd5) ? dig + 4'd3 : dig;
    end
    shifted = {bcd_adj, bin_q} << 1;

    run_d = run_q;
    cnt_d = cnt_q;
    bin_d = bin_q;
    bcd_d = bcd_q;
    if (start_i) begin
      run_d = 1'b1;
      cnt_d = '0;
      bin_d = bin_i;
      bcd_d = '0;
    end else if (run_q) begin
      bcd_d = shifted[BCD_W+WIDTH-1:WIDTH];
      bin_d = shifted[WIDTH-1:0];
      cnt_d = cnt_q + CNT_W'(1);
      if (done_c) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      bin_q <= '0;
      bcd_q <= '0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
      bin_q <= bin_d;
      bcd_q <= bcd_d;
    end
  end

endmodule

// File: rtl/seven_seg_mux.sv
// Multi-digit multiplexed seven-segment driver: captures a value, converts to
// decimal (or passes hex), formats sign/blanking/overflow and scans the digits.
module seven_seg_mux #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned WIDTH    = 12,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  value,
  input  logic              load,
  input  logic              signed_mode,
  input  logic              hex_mode,
  input  logic [DIGITS-1:0] dp_mask,
  output logic              busy,
  output logic [6:0]        seg_n,
  output logic              dp_n,
  output logic [DIGITS-1:0] an_n
);
  import seven_seg_pkg::*;

  localparam int unsigned NDIG      = DIGITS + 1;
  localparam int unsigned BCD_W     = 4 * NDIG;
  localparam int unsigned IDX_W     = $clog2(DIGITS);
  localparam int unsigned PSC_W     = $clog2(SCAN_DIV);
  localparam int unsigned HEX_W     = (4 * DIGITS > WIDTH) ? 4 * DIGITS : WIDTH;
  localparam int unsigned DEC_LIMIT = 10 ** DIGITS;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    value_q;
  logic                hex_q, neg_q, big_q;
  logic [DIGITS-1:0]   dp_mask_q;
  logic [6:0]          disp_seg_q [DIGITS];
  logic [DIGITS-1:0]   disp_dp_q;
  logic [PSC_W-1:0]    psc_q, psc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                busy_q;
  logic [6:0]          seg_n_q;
  logic                dp_n_q;
  logic [DIGITS-1:0]   an_n_q;

  logic                capture, neg_c, conv_done_c;
  logic [WIDTH:0]      sx_c, mag_c;
  logic [BCD_W-1:0]    bcd;
  logic [HEX_W-1:0]    hex_ext;
  logic [3:0]          nib [DIGITS];
  logic [IDX_W-1:0]    msd;
  logic                ovf;
  logic [6:0]          fmt_seg [DIGITS];
  logic [DIGITS-1:0]   fmt_dp;

  assign busy  = busy_q;
  assign seg_n = seg_n_q;
  assign dp_n  = dp_n_q;
  assign an_n  = an_n_q;

  // Magnitude is taken one bit wider so the most negative input negates exactly.
  assign capture = (state_q == S_IDLE) && load;
  assign neg_c   = signed_mode && !hex_mode && value[WIDTH-1];
  assign sx_c    = {neg_c, value};
  assign mag_c   = neg_c ? (~sx_c + (WIDTH+1)'(1)) : sx_c;

  bin2bcd_seq #(
    .WIDTH (WIDTH),
    .NDIG  (NDIG)
  ) u_bin2bcd (
    .clk     (clk),
    .reset   (reset),
    .start_i (capture && !hex_mode),
    .bin_i   (mag_c[WIDTH-1:0]),
    .bcd_o   (bcd),
    .done_c  (conv_done_c)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (load) state_d = hex_mode ? S_FORMAT : S_SHIFT;
      S_SHIFT:  if (conv_done_c) state_d = S_FORMAT;
      S_FORMAT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Display formatting from the captured value / finished BCD result.
  always_comb begin
    hex_ext = HEX_W'(value_q);
    msd     = '0;
    fmt_dp  = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      nib[i]     = hex_q ? hex_ext[4*i +: 4] : bcd[4*i +: 4];
      fmt_seg[i] = SEG_BLANK;
    end
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (nib[i] != 4'd0) msd = IDX_W'(i);
    end
    if (hex_q) ovf = |(hex_ext >> (4 * DIGITS));
    else       ovf = (bcd[BCD_W-1 -: 4] != 4'd0) || big_q ||
                     (neg_q && (msd == IDX_W'(DIGITS - 1)));
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (ovf) begin
        fmt_seg[i] = SEG_MINUS;
      end else begin
        fmt_dp[i] = dp_mask_q[i];
        if (i <= int'(msd))                    fmt_seg[i] = nib2seg(nib[i]);
        else if (neg_q && i == int'(msd) + 1)  fmt_seg[i] = SEG_MINUS;
        else                                   fmt_seg[i] = SEG_BLANK;
      end
    end
  end

  always_comb begin
    psc_d = psc_q + PSC_W'(1);
    idx_d = idx_q;
    if (psc_q == PSC_W'(SCAN_DIV - 1)) begin
      psc_d = '0;
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      value_q   <= '0;
      hex_q     <= 1'b0;
      neg_q     <= 1'b0;
      big_q     <= 1'b0;
      dp_mask_q <= '0;
      disp_dp_q <= '0;
      for (int i = 0; i < int'(DIGITS); i++) disp_seg_q[i] <= SEG_BLANK;
      psc_q     <= '0;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      seg_n_q   <= SEG_BLANK;
      dp_n_q    <= 1'b1;
      an_n_q    <= '1;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != S_IDLE);
      if (capture) begin
        value_q   <= value;
        hex_q     <= hex_mode;
        neg_q     <= neg_c;
        big_q     <= !hex_mode && (32'(mag_c) >= DEC_LIMIT);
        dp_mask_q <= dp_mask;
      end
      if (state_q == S_FORMAT) begin
        disp_seg_q <= fmt_seg;
        disp_dp_q  <= fmt_dp;
      end
      psc_q   <= psc_d;
      idx_q   <= idx_d;
      an_n_q  <= ~(DIGITS'(1) << idx_q);
      seg_n_q <= disp_seg_q[idx_q];
      dp_n_q  <= ~disp_dp_q[idx_q];
    end
  end

endmodule

// File: tb/tb_seven_seg_mux.sv
// Randomised self-checking bench for seven_seg_mux with an arithmetic display model.
module tb_seven_seg_mux;

  localparam int D  = 4;
  localparam int W  = 12;
  localparam int SD = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load = 1'b0;
  logic          signed_mode = 1'b0;
  logic          hex_mode = 1'b0;
  logic [W-1:0]  value = '0;
  logic [D-1:0]  dp_mask = '0;
  logic          busy;
  logic [6:0]    seg_n;
  logic          dp_n;
  logic [D-1:0]  an_n;

  int total = 0;
  int bad   = 0;

  logic [6:0] exp_seg [D];
  logic       exp_dp  [D];

  always #5 clk = ~clk;

  seven_seg_mux #(.DIGITS(D), .WIDTH(W), .SCAN_DIV(SD)) dut (
    .clk         (clk),
    .reset       (reset),
    .value       (value),
    .load        (load),
    .signed_mode (signed_mode),
    .hex_mode    (hex_mode),
    .dp_mask     (dp_mask),
    .busy        (busy),
    .seg_n       (seg_n),
    .dp_n        (dp_n),
    .an_n        (an_n)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Active-low glyph per digit value; 16 stands for the minus sign, 17 for blank.
  function automatic logic [6:0] glyph(input int n);
    case (n)
      0:  return 7'h40;  1:  return 7'h79;  2:  return 7'h24;  3:  return 7'h30;
      4:  return 7'h19;  5:  return 7'h12;  6:  return 7'h02;  7:  return 7'h78;
      8:  return 7'h00;  9:  return 7'h10;  10: return 7'h08;  11: return 7'h03;
      12: return 7'h46;  13: return 7'h21;  14: return 7'h06;  15: return 7'h0E;
      16: return 7'h3F;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic model(input logic [W-1:0] v, input logic s, input logic h,
                       input logic [D-1:0] m);
    int mag, base, nd, tmp;
    bit neg, ovf;
    base = h ? 16 : 10;
    neg  = !h && s && v[W-1];
    mag  = neg ? (1 << W) - int'(v) : int'(v);
    nd   = 0;
    tmp  = mag;
    do begin
      nd++;
      tmp = tmp / base;
    end while (tmp > 0);
    ovf = (nd > D) || (neg && nd == D) || (h && ((int'(v) >> (4 * D)) != 0));
    for (int i = 0; i < D; i++) begin
      tmp = mag;
      for (int k = 0; k < i; k++) tmp = tmp / base;
      if (ovf)                   exp_seg[i] = glyph(16);
      else if (i < nd)           exp_seg[i] = glyph(tmp % base);
      else if (neg && i == nd)   exp_seg[i] = glyph(16);
      else                       exp_seg[i] = glyph(17);
      exp_dp[i] = ovf ? 1'b1 : ~m[i];
    end
  endtask

  task automatic set_blank();
    for (int i = 0; i < D; i++) begin
      exp_seg[i] = 7'h7F;
      exp_dp[i]  = 1'b1;
    end
  endtask

  // Issues a load at the current negedge and measures how long busy stays high.
  task automatic run_load(input logic [W-1:0] v, input logic s, input logic h,
                          input logic [D-1:0] m, input bit inject, input string name);
    int cyc, expc;
    value = v; signed_mode = s; hex_mode = h; dp_mask = m; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      if (inject && cyc == 5) begin
        value = W'(99); signed_mode = 1'b0; hex_mode = 1'b0; load = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0;
    expc = h ? 1 : W + 1;
    total++;
    if (cyc !== expc) begin
      bad++;
      $display("FAIL %s busy_len got=%0d want=%0d", name, cyc, expc);
    end
    model(v, s, h, m);
  endtask

  task automatic check_display(input string name);
    int idx;
    logic [D-1:0] seen;
    seen = '0;
    repeat (2 * D * SD) begin
      @(negedge clk);
      idx = -1;
      for (int i = 0; i < D; i++) if (an_n === ~(D'(1) << i)) idx = i;
      total++;
      if (idx < 0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL %s an_onehot/busy an_n=%b busy=%b", name, an_n, busy);
      end else begin
        seen[idx] = 1'b1;
        total++;
        if (seg_n !== exp_seg[idx] || dp_n !== exp_dp[idx]) begin
          bad++;
          $display("FAIL %s digit%0d seg_n=%h dp_n=%b want seg_n=%h dp_n=%b",
                   name, idx, seg_n, dp_n, exp_seg[idx], exp_dp[idx]);
        end
      end
    end
    total++;
    if (seen !== '1) begin
      bad++;
      $display("FAIL %s scan_coverage got=%b want=%b", name, seen, {D{1'b1}});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || seg_n !== 7'h7F || dp_n !== 1'b1 || an_n !== '1) begin
      bad++;
      $display("FAIL reset_state busy=%b seg_n=%h dp_n=%b an_n=%b want 0 7f 1 1111",
               busy, seg_n, dp_n, an_n);
    end
    reset = 1'b0;
  endtask

  task automatic test_idle_scan();
    logic [D-1:0] exp_an;
    for (int k = 1; k <= 5 * D; k++) begin
      @(negedge clk);
      exp_an = ~(D'(1) << (((k - 1) / SD) % D));
      total++;
      if (an_n !== exp_an || seg_n !== 7'h7F || dp_n !== 1'b1) begin
        bad++;
        $display("FAIL idle_scan k=%0d an_n=%b seg_n=%h dp_n=%b want an_n=%b seg_n=7f dp_n=1",
                 k, an_n, seg_n, dp_n, exp_an);
      end
    end
  endtask

  task automatic test_decimal();
    run_load(W'(1234), 1'b0, 1'b0, 4'b0000, 1'b1, "dec1234");
    check_display("dec1234");
  endtask

  task automatic test_signed();
    run_load(12'hFFB, 1'b1, 1'b0, 4'b0001, 1'b0, "neg5");
    check_display("neg5");
  endtask

  task automatic test_overflow();
    run_load(12'h800, 1'b1, 1'b0, 4'b1111, 1'b0, "ovf_neg");
    check_display("ovf_neg");
  endtask

  task automatic test_hex();
    run_load(12'hABC, 1'b1, 1'b1, 4'b0000, 1'b0, "hexabc");
    check_display("hexabc");
  endtask

  task automatic test_zero();
    run_load(W'(0), 1'b0, 1'b0, 4'b0000, 1'b0, "zero");
    check_display("zero");
  endtask

  task automatic test_back_to_back();
    run_load(12'h123, 1'b0, 1'b1, 4'b0000, 1'b0, "b2b_hex");
    run_load(W'(456), 1'b0, 1'b0, 4'b0100, 1'b0, "b2b_dec");
    check_display("b2b_dec");
  endtask

  task automatic test_random();
    logic [W-1:0] v;
    logic s, h;
    logic [D-1:0] m;
    for (int n = 0; n < 16; n++) begin
      v = W'($urandom_range(0, (1 << W) - 1));
      s = 1'($urandom_range(0, 1));
      h = 1'($urandom_range(0, 1));
      m = D'($urandom_range(0, (1 << D) - 1));
      run_load(v, s, h, m, 1'b0, "random");
      check_display("random");
    end
  endtask

  task automatic test_reset_mid_shift();
    value = W'(1234); signed_mode = 1'b0; hex_mode = 1'b0; dp_mask = '0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL midshift_busy got=%b want=1", busy);
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || seg_n !== 7'h7F || dp_n !== 1'b1 || an_n !== '1) begin
      bad++;
      $display("FAIL midshift_abort busy=%b seg_n=%h dp_n=%b an_n=%b want 0 7f 1 1111",
               busy, seg_n, dp_n, an_n);
    end
    reset = 1'b0;
    set_blank();
    check_display("after_abort");
    run_load(W'(7), 1'b0, 1'b0, 4'b0000, 1'b0, "load7");
    check_display("load7");
  endtask

  initial begin
    set_blank();
    test_reset();
    test_idle_scan();
    test_decimal();
    test_signed();
    test_overflow();
    test_hex();
    test_zero();
    test_back_to_back();
    test_random();
    test_reset_mid_shift();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seven_seg_mux.md
# seven_seg_mux

Multi-digit, time-multiplexed seven-segment display driver. It captures a binary value on a load strobe and converts it to decimal sequentially, or passes it through as hex. It then applies sign, leading-zero blanking and overflow formatting, and scans the result across `DIGITS` common-anode digits. It replaces the single-digit combinational decoder on the board top level wherever more than one digit or values wider than 4 bits are displayed.

## Interface
- `DIGITS`, 4: number of physical digits (2..8).
- `WIDTH`, 12: input value width (4..24).
- `SCAN_DIV`, 50000: clock cycles per digit dwell (≥2).

Ports:
- `clk` input 1: single clock.
- `reset` input 1: synchronous, active-high reset.
- `value` input `WIDTH`: binary value to display.
- `load` input 1: capture request, 1-cycle strobe.
- `signed_mode` input 1: treat `value` as two's complement (decimal mode only).
- `hex_mode` input 1: 1 = hex nibbles, 0 = decimal.
- `dp_mask` input `DIGITS`: decimal point per digit, 1 = lit; bit 0 = rightmost digit.
- `busy` output 1: conversion in progress.
- `seg_n` output 7: segments a..g in bits 0..6, active-low.
- `dp_n` output 1: decimal point, active-low.
- `an_n` output `DIGITS`: digit enables, active-low, one-hot.

## Operation
- FSM states: IDLE, SHIFT, FORMAT.
- IDLE + `load`: capture `value`, `signed_mode`, `hex_mode` and `dp_mask`.
  - Decimal mode goes to SHIFT.
  - Hex mode goes straight to FORMAT.
- `load` while `busy` = 1 is ignored; nothing is queued.
- Signed decimal with a negative value: the magnitude is the two's-complement negation, computed as `WIDTH`+1 bits so that -2^(WIDTH-1) is exact.
- SHIFT runs double-dabble for exactly `WIDTH` cycles: add 3 to each BCD digit ≥5, then shift left one bit. The internal BCD register holds `DIGITS`+1 digits.
- FORMAT, one cycle; the display registers update atomically at the end of it:
  - Leading-zero blanking applies to digits above the most significant nonzero digit. Digit 0 is never blanked.
  - Negative values place a minus in the digit immediately left of the most significant shown digit.
  - Overflow occurs when any of these holds:
    - the decimal result needs more than `DIGITS` digits;
    - the value is negative and there is no free digit for the minus;
    - in hex mode, any `value` bit at index ≥ 4·`DIGITS` is set.
  - On overflow, every digit shows minus and `dp_mask` is ignored (all points off).
  - In hex mode, `signed_mode` is ignored and nibbles A–F use the standard a..g glyphs.
- Scan: a prescaler counts 0..`SCAN_DIV`-1. At the terminal count the digit index advances, wrapping from `DIGITS`-1 to 0. `an_n` drives the indexed digit low.
- `seg_n` and `dp_n` come from the display register of the current index. A blanked digit gives `seg_n` = 7'h7F with its anode still enabled.

## Timing
- Reset values: `busy` 0, `seg_n` 7'h7F, `dp_n` 1, `an_n` all ones for one cycle, then digit 0 active (1110 for 4 digits). Prescaler 0, index 0, FSM IDLE, all display digits blank.
- A synchronous `reset` during SHIFT or FORMAT aborts the conversion. The display goes blank; it does not hold its prior contents.
- `busy` rises on the edge that samples `load`.
  - Decimal: `busy` stays high for `WIDTH`+1 cycles.
  - Hex: `busy` stays high for 1 cycle.
- `busy` falls on the same edge that commits the display registers. `load` is accepted on that next cycle.
- `seg_n`, `dp_n` and `an_n` are all registered and change on the same edge. New content is visible one cycle after commit, at whatever digit is currently scanned.
- The scan never stalls for conversion, reset excepted.

## Structure
- Package `seven_seg_pkg` holds:
  - active-low glyph constants: `SEG_BLANK` = 7'h7F, `SEG_MINUS` = 7'b0111111, and digit glyphs (e.g. 0 = 7'b1000000, 1 = 7'b1111001, 2 = 7'b0100100, 5 = 7'b0010010);
  - a function mapping a nibble to its glyph;
  - the FSM state enum.
- Sub-module `bin2bcd_seq`: a sequential double-dabble converter with start/done handshake, parametrised on `WIDTH` and the number of BCD digits. The top level owns the FSM, formatting and scan.

## Test plan
- Use `DIGITS`=4, `WIDTH`=12, `SCAN_DIV`=4 throughout.
- Reset then idle: `an_n` cycles 1110→1101→1011→0111→1110 every 4 cycles with `seg_n` = 7'h7F on every digit.
- Unsigned decimal 1234: `busy` high exactly 13 cycles, then digits 3..0 show 1,2,3,4. A `load` of 99 issued mid-conversion has no effect.
- Signed decimal 12'hFFB: digits 3..0 show blank, blank, minus, 5. With `dp_mask` = 0001, `dp_n` = 0 only on digit 0.
- Overflow: signed 12'h800 (-2048) shows minus on all four digits with all points off. Hex 12'hABC shows blank, A, B, C after 1 busy cycle. Value 0 shows blank, blank, blank, 0.
- `reset` asserted on the 6th SHIFT cycle: next cycle `busy` = 0 and the display is blank. A following `load` of 7 displays 7 after 13 busy cycles.
